// File: rtl/noise_combiner.sv
//==============================================================================
// noise_combiner: DC-removes unsigned noise, scales it by a ramped gain and
//                 adds it to a complex signal stream with saturation.
// Revision: 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module noise_combiner #(
    parameter int unsigned RAMP_STEP = 64,
    parameter int unsigned GAIN_FRAC = 14
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] noise_real,
    input  logic [15:0] noise_imag,
    input  logic        sig_valid,
    output logic        sig_ready,
    input  logic [15:0] sig_real,
    input  logic [15:0] sig_imag,
    input  logic        noise_en,
    input  logic [15:0] gain_target,
    input  logic        gain_load,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_real,
    output logic [15:0] out_imag,
    output logic        out_sat,
    output logic [15:0] gain_current,
    output logic        ramp_busy
);

    localparam logic signed [32:0] c_ROUND  = 33'sd1 <<< (GAIN_FRAC - 1);
    localparam logic signed [32:0] c_SC_MAX = 33'sd131071;
    localparam logic signed [32:0] c_SC_MIN = -33'sd131072;
    localparam logic        [16:0] c_STEP   = 17'(RAMP_STEP);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        RAMP_DOWN = 2'd2
    } ramp_state_t;

    ramp_state_t state_q;
    logic [15:0] gain_q, gain_d, target_q;

    logic        en, accept;
    logic        s1_valid_q, s2_valid_q, out_valid_q;
    logic [15:0] s1_ns_re_q, s1_ns_im_q, s1_sig_re_q, s1_sig_im_q, s1_gain_q;
    logic [15:0] s2_sig_re_q, s2_sig_im_q;
    logic [17:0] s2_sc_re_q, s2_sc_im_q;
    logic [15:0] out_real_q, out_imag_q;
    logic        out_sat_q;
    logic [17:0] w_sc_re, w_sc_im;
    logic [16:0] w_sum_re, w_sum_im;

    function automatic logic [17:0] scale_clamp(input logic [15:0] ns, input logic [15:0] g);
        logic signed [32:0] prod;
        logic signed [32:0] shifted;
        prod    = 33'($signed(ns)) * $signed({17'b0, g});
        shifted = (prod + c_ROUND) >>> GAIN_FRAC;
        if (shifted > c_SC_MAX) begin
            return 18'h1FFFF;
        end else if (shifted < c_SC_MIN) begin
            return 18'h20000;
        end
        return shifted[17:0];
    endfunction

    // Result is {clipped, value}.
    function automatic logic [16:0] sat_add(input logic [15:0] s, input logic [17:0] sc);
        logic signed [18:0] sum;
        sum = 19'($signed(s)) + 19'($signed(sc));
        if (sum > 19'sd32767) begin
            return {1'b1, 16'h7FFF};
        end else if (sum < -19'sd32768) begin
            return {1'b1, 16'h8000};
        end
        return {1'b0, sum[15:0]};
    endfunction

    assign en        = !(out_valid_q && !out_ready);
    assign accept    = sig_valid && en;
    assign sig_ready = en;

    assign w_sc_re  = scale_clamp(s1_ns_re_q, s1_gain_q);
    assign w_sc_im  = scale_clamp(s1_ns_im_q, s1_gain_q);
    assign w_sum_re = sat_add(s2_sig_re_q, s2_sc_re_q);
    assign w_sum_im = sat_add(s2_sig_im_q, s2_sc_im_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            s1_ns_re_q  <= '0;
            s1_ns_im_q  <= '0;
            s1_sig_re_q <= '0;
            s1_sig_im_q <= '0;
            s1_gain_q   <= '0;
            s2_sig_re_q <= '0;
            s2_sig_im_q <= '0;
            s2_sc_re_q  <= '0;
            s2_sc_im_q  <= '0;
            out_real_q  <= '0;
            out_imag_q  <= '0;
            out_sat_q   <= 1'b0;
        end else if (en) begin
            s1_valid_q  <= accept;
            s2_valid_q  <= s1_valid_q;
            out_valid_q <= s2_valid_q;
            if (accept) begin
                // Subtracting 32768 from an unsigned word is an MSB flip.
                s1_ns_re_q  <= noise_real ^ 16'h8000;
                s1_ns_im_q  <= noise_imag ^ 16'h8000;
                s1_sig_re_q <= sig_real;
                s1_sig_im_q <= sig_imag;
                s1_gain_q   <= noise_en ? gain_q : 16'd0;
            end
            if (s1_valid_q) begin
                s2_sig_re_q <= s1_sig_re_q;
                s2_sig_im_q <= s1_sig_im_q;
                s2_sc_re_q  <= w_sc_re;
                s2_sc_im_q  <= w_sc_im;
            end
            if (s2_valid_q) begin
                out_real_q <= w_sum_re[15:0];
                out_imag_q <= w_sum_im[15:0];
                out_sat_q  <= w_sum_re[16] | w_sum_im[16];
            end
        end
    end

    // Gain only moves on accepted samples, clamped at the target in 17-bit math.
    always_comb begin
        gain_d = gain_q;
        if (accept) begin
            if (state_q == RAMP_UP) begin
                if (({1'b0, gain_q} + c_STEP) >= {1'b0, target_q}) begin
                    gain_d = target_q;
                end else begin
                    gain_d = gain_q + c_STEP[15:0];
                end
            end else if (state_q == RAMP_DOWN) begin
                if ({1'b0, gain_q} >= ({1'b0, target_q} + c_STEP)) begin
                    gain_d = gain_q - c_STEP[15:0];
                end else begin
                    gain_d = target_q;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            gain_q   <= '0;
            target_q <= '0;
        end else begin
            gain_q <= gain_d;
            if (gain_load) begin
                target_q <= gain_target;
                if (gain_target > gain_d) begin
                    state_q <= RAMP_UP;
                end else if (gain_target < gain_d) begin
                    state_q <= RAMP_DOWN;
                end else begin
                    state_q <= IDLE;
                end
            end else if (state_q != IDLE && gain_d == target_q) begin
                state_q <= IDLE;
            end
        end
    end

    assign out_valid    = out_valid_q;
    assign out_real     = out_real_q;
    assign out_imag     = out_imag_q;
    assign out_sat      = out_sat_q;
    assign gain_current = gain_q;
    assign ramp_busy    = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_noise_combiner.sv
//==============================================================================
// tb_noise_combiner: scoreboard bench for noise_combiner.
// Revision: 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_noise_combiner;

    logic        clk;
    logic        reset;
    logic [15:0] noise_real, noise_imag;
    logic        sig_valid, sig_ready;
    logic [15:0] sig_real, sig_imag;
    logic        noise_en;
    logic [15:0] gain_target;
    logic        gain_load;
    logic        out_valid, out_ready;
    logic [15:0] out_real, out_imag;
    logic        out_sat;
    logic [15:0] gain_current;
    logic        ramp_busy;

    noise_combiner #(.RAMP_STEP(64), .GAIN_FRAC(14)) dut (
        .clk          (clk),
        .reset        (reset),
        .noise_real   (noise_real),
        .noise_imag   (noise_imag),
        .sig_valid    (sig_valid),
        .sig_ready    (sig_ready),
        .sig_real     (sig_real),
        .sig_imag     (sig_imag),
        .noise_en     (noise_en),
        .gain_target  (gain_target),
        .gain_load    (gain_load),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_real     (out_real),
        .out_imag     (out_imag),
        .out_sat      (out_sat),
        .gain_current (gain_current),
        .ramp_busy    (ramp_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] re;
        logic [15:0] im;
        logic        sat;
    } exp_t;

    exp_t        sb_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          gain_model = 0;
    int          n_out = 0;
    int          stall_cnt = 0;
    logic        stall_prev = 1'b0;
    logic [15:0] held_re, held_im;
    logic        held_sat;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Returns {clipped, value} for one component.
    function automatic logic [16:0] model_comp(input logic [15:0] n, input logic [15:0] s, input int g);
        longint ns, p, sc, sum;
        logic [15:0] v;
        ns = longint'(n) - 64'sd32768;
        p  = ns * longint'(g);
        sc = (p + 64'sd8192) >>> 14;
        if (sc > 64'sd131071)  sc = 64'sd131071;
        if (sc < -64'sd131072) sc = -64'sd131072;
        sum = longint'($signed(s)) + sc;
        if (sum > 64'sd32767)  return {1'b1, 16'h7FFF};
        if (sum < -64'sd32768) return {1'b1, 16'h8000};
        v = sum[15:0];
        return {1'b0, v};
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_re", 32'(out_real), 32'(held_re));
                chk("hold_im", 32'(out_imag), 32'(held_im));
                chk("hold_sat", 32'(out_sat), 32'(held_sat));
            end
            stall_prev = out_valid && !out_ready;
            if (stall_prev) begin
                stall_cnt++;
                held_re  = out_real;
                held_im  = out_imag;
                held_sat = out_sat;
                chk("stall_ready", 32'(sig_ready), 32'd0);
            end
            if (sig_valid && sig_ready) begin
                logic [16:0] er, ei;
                int g;
                exp_t e;
                g  = noise_en ? gain_model : 0;
                er = model_comp(noise_real, sig_real, g);
                ei = model_comp(noise_imag, sig_imag, g);
                e.re  = er[15:0];
                e.im  = ei[15:0];
                e.sat = er[16] | ei[16];
                sb_q.push_back(e);
            end
            if (out_valid && out_ready) begin
                n_out++;
                if (sb_q.size() == 0) begin
                    chk("unexpected_out", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("sb_re", 32'(out_real), 32'(e.re));
                    chk("sb_im", 32'(out_imag), 32'(e.im));
                    chk("sb_sat", 32'(out_sat), 32'(e.sat));
                end
            end
        end
    end

    task automatic send(input logic [15:0] sr, input logic [15:0] si,
                        input logic [15:0] nr, input logic [15:0] ni, input logic nen);
        sig_valid  = 1'b1;
        sig_real   = sr;
        sig_imag   = si;
        noise_real = nr;
        noise_imag = ni;
        noise_en   = nen;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (sig_ready) begin
                @(posedge clk);
                #1;
                return;
            end
            @(posedge clk);
            #1;
        end
        chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        sig_valid = 1'b0;
        for (int k = 0; k < n; k++) begin
            noise_real = 16'($urandom);
            noise_imag = 16'($urandom);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_rand(input logic nen);
        send(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), nen);
    endtask

    task automatic load(input logic [15:0] g);
        sig_valid   = 1'b0;
        gain_target = g;
        gain_load   = 1'b1;
        @(posedge clk);
        #1;
        gain_load = 1'b0;
    endtask

    task automatic ramp_to(input logic [15:0] g);
        int k;
        load(g);
        k = 0;
        while (ramp_busy && k < 600) begin
            send_rand(1'b0);
            k++;
        end
        chk("ramp_done", 32'(ramp_busy), 32'd0);
        chk("ramp_gain", 32'(gain_current), 32'(g));
        gain_model = int'(g);
    endtask

    task automatic send_and_expect(input logic [15:0] sr, input logic [15:0] si,
                                   input logic [15:0] nr, input logic [15:0] ni, input logic nen,
                                   input logic [15:0] er, input logic [15:0] ei, input logic es);
        send(sr, si, nr, ni, nen);
        sig_valid = 1'b0;
        chk("lat_n1", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("lat_n2", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("lat_n3", 32'(out_valid), 32'd1);
        chk("direct_re", 32'(out_real), 32'(er));
        chk("direct_im", 32'(out_imag), 32'(ei));
        chk("direct_sat", 32'(out_sat), 32'(es));
        idle(2);
    endtask

    initial begin
        int base_out;
        logic [15:0] exp_dn;
        reset       = 1'b0;
        out_ready   = 1'b1;
        sig_valid   = 1'b0;
        sig_real    = '0;
        sig_imag    = '0;
        noise_real  = '0;
        noise_imag  = '0;
        noise_en    = 1'b0;
        gain_target = '0;
        gain_load   = 1'b0;
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_gain", 32'(gain_current), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        chk("rel_ready", 32'(sig_ready), 32'd1);
        chk("rel_busy", 32'(ramp_busy), 32'd0);
        chk("rel_gain", 32'(gain_current), 32'd0);
        idle(2);

        // Noise disabled: output equals signal, three-cycle latency
        send_and_expect(16'd1000, 16'hFC18, 16'h1234, 16'hEDCB, 1'b0, 16'd1000, 16'hFC18, 1'b0);

        // Ramp up to 256 then down to 100 in steps of 64
        load(16'd256);
        chk("up_busy", 32'(ramp_busy), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            send_rand(1'b0);
            chk("up_gain", 32'(gain_current), 32'(64 * i));
        end
        chk("up_idle", 32'(ramp_busy), 32'd0);
        load(16'd100);
        chk("dn_busy", 32'(ramp_busy), 32'd1);
        for (int i = 0; i < 3; i++) begin
            exp_dn = (i == 0) ? 16'd192 : (i == 1) ? 16'd128 : 16'd100;
            send_rand(1'b0);
            chk("dn_gain", 32'(gain_current), 32'(exp_dn));
        end
        chk("dn_idle", 32'(ramp_busy), 32'd0);
        idle(3);

        // Unity gain: plain offset noise and saturating sums
        ramp_to(16'd16384);
        idle(3);
        send_and_expect(16'd100, 16'd100, 16'h9000, 16'h7000, 1'b1, 16'd4196, 16'hF064, 1'b0);
        send_and_expect(16'd32000, 16'h8300, 16'hFFFC, 16'h0000, 1'b1, 16'h7FFF, 16'h8000, 1'b1);
        for (int i = 0; i < 8; i++) send_rand(1'($urandom));
        idle(4);

        // Fractional gain exercises rounding
        ramp_to(16'd10000);
        idle(3);
        for (int i = 0; i < 8; i++) send_rand(1'b1);
        idle(4);

        // Ten-sample stream with a five-cycle downstream stall
        base_out  = n_out;
        stall_cnt = 0;
        fork
            begin
                for (int i = 0; i < 10; i++) send_rand(1'b1);
                sig_valid = 1'b0;
            end
            begin
                repeat (4) begin @(posedge clk); #1; end
                out_ready = 1'b0;
                repeat (5) begin @(posedge clk); #1; end
                out_ready = 1'b1;
            end
        join
        idle(6);
        chk("stall_cycles", 32'(stall_cnt), 32'd5);
        chk("stream_count", 32'(n_out - base_out), 32'd10);
        chk("stream_drain", 32'(sb_q.size()), 32'd0);

        // Asynchronous reset with samples in flight
        for (int i = 0; i < 3; i++) send_rand(1'b1);
        #3;
        reset = 1'b0;
        #1;
        chk("ar_valid", 32'(out_valid), 32'd0);
        chk("ar_re", 32'(out_real), 32'd0);
        chk("ar_im", 32'(out_imag), 32'd0);
        chk("ar_sat", 32'(out_sat), 32'd0);
        chk("ar_gain", 32'(gain_current), 32'd0);
        chk("ar_busy", 32'(ramp_busy), 32'd0);
        sb_q.delete();
        gain_model = 0;
        sig_valid  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        chk("ar_rel_ready", 32'(sig_ready), 32'd1);
        chk("ar_rel_busy", 32'(ramp_busy), 32'd0);
        chk("ar_rel_gain", 32'(gain_current), 32'd0);
        for (int i = 0; i < 5; i++) begin
            chk("ar_flushed", 32'(out_valid), 32'd0);
            idle(1);
        end
        send_and_expect(16'h7FF0, 16'h8010, 16'hFFFF, 16'h0000, 1'b1, 16'h7FF0, 16'h8010, 1'b0);
        idle(3);
        chk("final_drain", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule

`default_nettype wire
